// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA raster timing generator with an update-toggle to move_tick converter.
// Build option MOVE_VBLANK_SYNC_EN: when defined, move_tick is deferred to the vblank point (x=0, y=V_VISIBLE).
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       update,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start,
    output logic       move_tick
);
    // Legal range: every H/V parameter >= 1 and both totals <= 1024.
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       video_next;
    logic       hsync_next;
    logic       vsync_next;
    logic       frame_next;

    logic       sync1;
    logic       sync2;
    logic       sync3;
    logic       upd_edge;

    always_comb begin
        x_next = pixel_x + 10'd1;
        y_next = pixel_y;
        if (pixel_x == H_MAX) begin
            x_next = '0;
            y_next = (pixel_y == V_MAX) ? 10'd0 : pixel_y + 10'd1;
        end
    end

    // Decodes look at the next counter values so the registered outputs line up with pixel_x/pixel_y.
    always_comb begin
        video_next = (x_next < H_VIS) && (y_next < V_VIS);
        hsync_next = !((x_next >= HS_START) && (x_next < HS_END));
        vsync_next = !((y_next >= VS_START) && (y_next < VS_END));
        frame_next = (x_next == 10'd0) && (y_next == 10'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_x     <= H_MAX;
            pixel_y     <= V_MAX;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_x     <= x_next;
            pixel_y     <= y_next;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            video_on    <= video_next;
            frame_start <= frame_next;
        end
    end

    // Two flops resolve metastability on the asynchronous toggle; the third holds the previous level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= update;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign upd_edge = sync2 ^ sync3;

`ifdef MOVE_VBLANK_SYNC_EN
    logic pending;
    logic vblank_next;

    assign vblank_next = (x_next == 10'd0) && (y_next == V_VIS);

    // Edges collapse into pending; an edge arriving on the vblank cycle itself is still honoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            move_tick <= 1'b0;
        end else if (vblank_next) begin
            pending   <= 1'b0;
            move_tick <= pending | upd_edge;
        end else begin
            pending   <= pending | upd_edge;
            move_tick <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_tick <= 1'b0;
        end else begin
            move_tick <= upd_edge;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-size instance for line timing and a shrunken
// instance so whole frames and vblank move scheduling fit in a short run.
module tb_vga_sync_gen;
    localparam int SHV = 16, SHF = 2, SHS = 4, SHB = 3;
    localparam int SVV = 12, SVF = 2, SVS = 2, SVB = 3;
    localparam int S_HT = SHV + SHF + SHS + SHB;
    localparam int S_VT = SVV + SVF + SVS + SVB;
    localparam int S_FRAME = S_HT * S_VT;
`ifdef MOVE_VBLANK_SYNC_EN
    localparam bit DEFER = 1'b1;
`else
    localparam bit DEFER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic update = 1'b0;

    logic       d_hs, d_vs, d_vid, d_fs, d_mt;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_vid, s_fs, s_mt;
    logic [9:0] s_x, s_y;

    vga_sync_gen dut (
        .clk(clk), .rst_n(rst_n), .update(update),
        .hsync(d_hs), .vsync(d_vs), .video_on(d_vid),
        .pixel_x(d_x), .pixel_y(d_y),
        .frame_start(d_fs), .move_tick(d_mt)
    );

    vga_sync_gen #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .update(update),
        .hsync(s_hs), .vsync(s_vs), .video_on(s_vid),
        .pixel_x(s_x), .pixel_y(s_y),
        .frame_start(s_fs), .move_tick(s_mt)
    );

    always #20 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n = 0;
    int d_q[$];
    logic pend_d = 1'b0;
    logic pend_s = 1'b0;
    int scan_bad_d = 0;
    int scan_bad_s = 0;
    int first_bad_d = -1;
    int first_bad_s = -1;
    int ticks_s = 0;
    int exp_ticks_s = 0;

    typedef struct {
        int n;
        bit sel;
        int x;
        int y;
        bit vid;
        bit hs;
        bit vs;
        bit fs;
        bit mt;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (n=%0d)", name, act, exp, n);
        end
    endtask

    // Reference raster: position is simply the cycle count since reset release modulo the frame.
    function automatic logic [23:0] raster(input int cyc, input int hv, input int hf, input int hsw,
                                           input int hb, input int vv, input int vf, input int vsw,
                                           input int vb);
        int ht, vt, p, x, y;
        logic hs, vs, vid, fs;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (cyc == 0) begin
            x = ht - 1; y = vt - 1; hs = 1'b1; vs = 1'b1; vid = 1'b0; fs = 1'b0;
        end else begin
            p = (cyc - 1) % (ht * vt);
            x = p % ht;
            y = p / ht;
            vid = (x < hv) && (y < vv);
            hs = !((x >= hv + hf) && (x < hv + hf + hsw));
            vs = !((y >= vv + vf) && (y < vv + vf + vsw));
            fs = (x == 0) && (y == 0);
        end
        return {x[9:0], y[9:0], hs, vs, vid, fs};
    endfunction

    function automatic bit is_vblank(input int cyc, input int ht, input int vt, input int vv);
        return (cyc > 0) && (((cyc - 1) % (ht * vt)) == vv * ht);
    endfunction

    task automatic step(input bit tog);
        logic edge_now;
        logic exp_mt_d, exp_mt_s;
        logic [24:0] exp_d, exp_s, act_d, act_s;
        @(posedge clk);
        n++;
        edge_now = 1'b0;
        while (d_q.size() > 0 && d_q[0] <= n) begin
            if (d_q[0] == n) edge_now = 1'b1;
            void'(d_q.pop_front());
        end
        if (DEFER) begin
            if (is_vblank(n, 800, 525, 480)) begin
                exp_mt_d = pend_d | edge_now; pend_d = 1'b0;
            end else begin
                exp_mt_d = 1'b0; pend_d = pend_d | edge_now;
            end
            if (is_vblank(n, S_HT, S_VT, SVV)) begin
                exp_mt_s = pend_s | edge_now; pend_s = 1'b0;
            end else begin
                exp_mt_s = 1'b0; pend_s = pend_s | edge_now;
            end
        end else begin
            exp_mt_d = edge_now;
            exp_mt_s = edge_now;
        end
        #1;
        if (tog) begin
            update = ~update;
            d_q.push_back(n + 3);
        end
        @(negedge clk);
        exp_d = {raster(n, 640, 16, 96, 48, 480, 10, 2, 33), exp_mt_d};
        exp_s = {raster(n, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB), exp_mt_s};
        act_d = {d_x, d_y, d_hs, d_vs, d_vid, d_fs, d_mt};
        act_s = {s_x, s_y, s_hs, s_vs, s_vid, s_fs, s_mt};
        if (act_d !== exp_d) begin
            scan_bad_d++;
            if (first_bad_d < 0) first_bad_d = n;
        end
        if (act_s !== exp_s) begin
            scan_bad_s++;
            if (first_bad_s < 0) first_bad_s = n;
        end
        if (s_mt === 1'b1) ticks_s++;
        if (exp_mt_s) exp_ticks_s++;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        n = 0;
        d_q.delete();
        pend_d = 1'b0;
        pend_s = 1'b0;
        #1;
        check("rst_d_x", int'(d_x), 799);
        check("rst_d_y", int'(d_y), 524);
        check("rst_d_hs", int'(d_hs), 1);
        check("rst_d_vs", int'(d_vs), 1);
        check("rst_d_vid", int'(d_vid), 0);
        check("rst_d_fs", int'(d_fs), 0);
        check("rst_d_mt", int'(d_mt), 0);
        check("rst_s_x", int'(s_x), S_HT - 1);
        check("rst_s_y", int'(s_y), S_VT - 1);
        check("rst_s_mt", int'(s_mt), 0);
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        if (update) d_q.push_back(3);
    endtask

    initial begin
        vec_t tbl[24];
        int defer_ticks;
        tbl[0]  = '{1,   1'b0, 0,   0,  1, 1, 1, 1, 0};
        tbl[1]  = '{1,   1'b1, 0,   0,  1, 1, 1, 1, 0};
        tbl[2]  = '{2,   1'b0, 1,   0,  1, 1, 1, 0, 0};
        tbl[3]  = '{17,  1'b1, 16,  0,  0, 1, 1, 0, 0};
        tbl[4]  = '{19,  1'b1, 18,  0,  0, 0, 1, 0, 0};
        tbl[5]  = '{22,  1'b1, 21,  0,  0, 0, 1, 0, 0};
        tbl[6]  = '{23,  1'b1, 22,  0,  0, 1, 1, 0, 0};
        tbl[7]  = '{57,  1'b1, 6,   2,  1, 1, 1, 0, !DEFER};
        tbl[8]  = '{301, 1'b1, 0,   12, 0, 1, 1, 0, DEFER};
        tbl[9]  = '{350, 1'b1, 24,  13, 0, 1, 1, 0, 0};
        tbl[10] = '{351, 1'b1, 0,   14, 0, 1, 0, 0, 0};
        tbl[11] = '{400, 1'b1, 24,  15, 0, 1, 0, 0, 0};
        tbl[12] = '{401, 1'b1, 0,   16, 0, 1, 1, 0, 0};
        tbl[13] = '{475, 1'b1, 24,  18, 0, 1, 1, 0, 0};
        tbl[14] = '{476, 1'b1, 0,   0,  1, 1, 1, 1, 0};
        tbl[15] = '{640, 1'b0, 639, 0,  1, 1, 1, 0, 0};
        tbl[16] = '{641, 1'b0, 640, 0,  0, 1, 1, 0, 0};
        tbl[17] = '{656, 1'b0, 655, 0,  0, 1, 1, 0, 0};
        tbl[18] = '{657, 1'b0, 656, 0,  0, 0, 1, 0, 0};
        tbl[19] = '{752, 1'b0, 751, 0,  0, 0, 1, 0, 0};
        tbl[20] = '{753, 1'b0, 752, 0,  0, 1, 1, 0, 0};
        tbl[21] = '{776, 1'b1, 0,   12, 0, 1, 1, 0, 0};
        tbl[22] = '{800, 1'b0, 799, 0,  0, 1, 1, 0, 0};
        tbl[23] = '{801, 1'b0, 0,   1,  1, 1, 1, 0, 0};

        do_reset(5);

        // Table walk; update toggles at small-raster (3,2) and (10,8) exercise deferral.
        for (int i = 0; i < 24; i++) begin
            while (n < tbl[i].n) step((n + 1 == 54) || (n + 1 == 211));
            if (tbl[i].sel) begin
                check($sformatf("tbl%0d_s_x", i), int'(s_x), tbl[i].x);
                check($sformatf("tbl%0d_s_y", i), int'(s_y), tbl[i].y);
                check($sformatf("tbl%0d_s_vid", i), int'(s_vid), int'(tbl[i].vid));
                check($sformatf("tbl%0d_s_hs", i), int'(s_hs), int'(tbl[i].hs));
                check($sformatf("tbl%0d_s_vs", i), int'(s_vs), int'(tbl[i].vs));
                check($sformatf("tbl%0d_s_fs", i), int'(s_fs), int'(tbl[i].fs));
                check($sformatf("tbl%0d_s_mt", i), int'(s_mt), int'(tbl[i].mt));
            end else begin
                check($sformatf("tbl%0d_d_x", i), int'(d_x), tbl[i].x);
                check($sformatf("tbl%0d_d_y", i), int'(d_y), tbl[i].y);
                check($sformatf("tbl%0d_d_vid", i), int'(d_vid), int'(tbl[i].vid));
                check($sformatf("tbl%0d_d_hs", i), int'(d_hs), int'(tbl[i].hs));
                check($sformatf("tbl%0d_d_vs", i), int'(d_vs), int'(tbl[i].vs));
                check($sformatf("tbl%0d_d_fs", i), int'(d_fs), int'(tbl[i].fs));
                check($sformatf("tbl%0d_d_mt", i), int'(d_mt), int'(tbl[i].mt));
            end
        end
        defer_ticks = ticks_s;
        check("defer_tick_count", defer_ticks, DEFER ? 1 : 2);

        // Edge detected exactly on the vblank cycle of the third small frame.
        while (n < 2 * S_FRAME + 301 - 4) step(1'b0);
        step(1'b1);
        while (n < 2 * S_FRAME + 301) step(1'b0);
        check("vblank_edge_mt", int'(s_mt), 1);

        repeat (1500) step($urandom_range(0, 30) == 0);

        // Toggle at small (0,2), then reset at (0,5): the pending move must be discarded.
        if (update == 1'b0) step(1'b1);
        while (n % S_FRAME != 50) step(1'b0);
        step(1'b1);
        while (n % S_FRAME != 125) step(1'b0);
        step(1'b0);
        do_reset(3);
        step(1'b0);
        check("rst2_s_x", int'(s_x), 0);
        check("rst2_s_y", int'(s_y), 0);
        check("rst2_s_fs", int'(s_fs), 1);
        check("rst2_d_fs", int'(d_fs), 1);
        while (n < 301) step(1'b0);
        check("rst2_discard_mt", int'(s_mt), 0);
        while (n < 476) step(1'b0);
        check("rst2_frame2_fs", int'(s_fs), 1);

        repeat (800) step($urandom_range(0, 25) == 0);

        check("scan_dflt_bad_cycles", scan_bad_d, 0);
        check("scan_small_bad_cycles", scan_bad_s, 0);
        check("small_tick_total", ticks_s, exp_ticks_s);
        if (first_bad_d >= 0 || first_bad_s >= 0)
            $display("first divergent cycle: default=%0d small=%0d", first_bad_d, first_bad_s);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
